qspi_stream_reader: RTL and testbench

- Sequences the external QSPI flash for the RLE VGA pipeline.
- On a start request it issues a Quad Output Fast Read (0x6B): single-line command and address, dummy clocks, then continuous 4-bit reads.
- Delivers 16-bit words to the RLE decoder over a valid/ready handshake, pausing the flash clock when the decoder back-pressures.
- Sits between the top-level uio pins and the RLE decoder; the same controller is reused for every frame restart.

---
 rtl/qspi_stream_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_qspi_stream_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_stream_reader.sv
// qspi_stream_reader: QSPI flash sequencer for the RLE VGA pipeline.
// Issues a Quad Output Fast Read (0x6B) and streams 16-bit words to the decoder.
//   clk, rst_n            : system clock, asynchronous active-low reset
//   start, stop, addr     : begin a read at addr / abort or end the current read
//   busy                  : high from start acceptance until back in IDLE
//   data, data_valid,
//   data_ready            : word output, valid/ready handshake (first nibble in [15:12])
//   spi_cs_n, spi_clk,
//   spi_mosi, spi_io0_oe  : flash chip select, SCK, IO0 value and enable
//   spi_miso              : IO3..IO0 read data
module qspi_stream_reader #(
  parameter int unsigned DUMMY_CYCLES   = 8,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [23:0] addr,
  output logic        busy,
  output logic [15:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_io0_oe,
  input  logic [3:0]  spi_miso
);

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned CNT_W     = 8;
  localparam logic [7:0]  CMD_QOFR  = 8'h6B;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CSH   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             phase_q, phase_d;       // 0 = SCK low half, 1 = SCK high half
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [30:0]      sh_q, sh_d;             // remaining command/address bits after the one on mosi
  logic [11:0]      nib_q, nib_d;
  logic [1:0]       nib_cnt_q, nib_cnt_d;
  logic             pend_q, pend_d;         // completed word waiting for the holding register
  logic [15:0]      pend_word_q, pend_word_d;
  logic [15:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             oe_q, oe_d;
  logic             hold_free;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      nib_q       <= '0;
      nib_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      nib_q       <= nib_d;
      nib_cnt_q   <= nib_cnt_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      oe_q        <= oe_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    nib_d       = nib_q;
    nib_cnt_d   = nib_cnt_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    oe_d        = oe_q;

    // Holding register can take a word if empty or being consumed this cycle
    hold_free = !valid_q || data_ready;
    if (valid_q && data_ready) valid_d = 1'b0;

    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_CSH;
      cnt_d     = '0;
      phase_d   = 1'b0;
      cs_n_d    = 1'b1;
      sck_d     = 1'b0;
      oe_d      = 1'b0;
      mosi_d    = 1'b0;
      valid_d   = 1'b0;
      pend_d    = 1'b0;
      nib_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_CMD;
            sh_d      = {CMD_QOFR[6:0], addr};
            mosi_d    = CMD_QOFR[7];
            cnt_d     = '0;
            phase_d   = 1'b0;
            nib_cnt_d = '0;
            pend_d    = 1'b0;
            cs_n_d    = 1'b0;
            oe_d      = 1'b1;
            busy_d    = 1'b1;
            sck_d     = 1'b0;
          end
        end
        S_CMD, S_ADDR, S_DUMMY: begin
          if (!phase_q) begin
            phase_d = 1'b1;
            sck_d   = 1'b1;
          end else begin
            // End of high half: advance to the next serial bit
            phase_d = 1'b0;
            sck_d   = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
            sh_d    = {sh_q[29:0], 1'b0};
            mosi_d  = (state_q == S_DUMMY) ? 1'b0 : sh_q[30];
            if ((state_q == S_CMD) && (cnt_q == CNT_W'(CMD_BITS - 1))) begin
              state_d = S_ADDR;
              cnt_d   = '0;
            end
            if ((state_q == S_ADDR) && (cnt_q == CNT_W'(ADDR_BITS - 1))) begin
              state_d = S_DUMMY;
              cnt_d   = '0;
              oe_d    = 1'b0;
              mosi_d  = 1'b0;
            end
            if ((state_q == S_DUMMY) && (cnt_q == CNT_W'(DUMMY_CYCLES - 1))) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end
          end
        end
        S_DATA: begin
          if (pend_q) begin
            // Stalled with SCK low: hand the pending word over before clocking again
            if (hold_free) begin
              data_d  = pend_word_q;
              valid_d = 1'b1;
              pend_d  = 1'b0;
            end
          end else if (!phase_q) begin
            phase_d = 1'b1;
            sck_d   = 1'b1;
          end else begin
            phase_d   = 1'b0;
            sck_d     = 1'b0;
            nib_d     = {nib_q[7:0], spi_miso};
            nib_cnt_d = nib_cnt_q + 2'd1;
            if (nib_cnt_q == 2'd3) begin
              if (hold_free) begin
                data_d  = {nib_q, spi_miso};
                valid_d = 1'b1;
              end else begin
                pend_d      = 1'b1;
                pend_word_d = {nib_q, spi_miso};
              end
            end
          end
        end
        S_CSH: begin
          if (cnt_q == CNT_W'(CS_HIGH_CYCLES - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_clk    = sck_q;
  assign spi_mosi   = mosi_q;
  assign spi_io0_oe = oe_q;

endmodule

// File: tb/tb_qspi_stream_reader.sv
// tb_qspi_stream_reader: self-checking bench for qspi_stream_reader.
// A flash model serves nibbles from a stream table indexed by SCK rising edges;
// a monitor checks the command/address bits and every accepted word against it.
`timescale 1ns/1ps
module tb_qspi_stream_reader;

  localparam int unsigned DUMMY      = 8;
  localparam int unsigned CSH        = 4;
  localparam int unsigned FIRST_DATA = 32 + DUMMY + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] addr = '0;
  logic        busy;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_io0_oe;
  logic [3:0]  spi_miso = '0;

  qspi_stream_reader #(.DUMMY_CYCLES(DUMMY), .CS_HIGH_CYCLES(CSH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .addr(addr),
    .busy(busy), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_io0_oe(spi_io0_oe), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Flash contents served after the dummy clocks, one nibble per SCK
  logic [3:0]  stream [256];
  logic [23:0] exp_addr = '0;
  logic [15:0] got_words [$];
  int          got_cyc [$];

  // Consumer ready: forced level or random
  bit rand_ready = 1'b0;
  bit ready_force = 1'b0;
  always @(posedge clk) begin
    #2;
    data_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Flash model and compare process
  int          rises = 0;
  int          acc_idx = 0;
  int          cyc = 0;
  logic [31:0] mosi_sh = '0;
  logic        prev_sck = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_stop = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    logic [7:0]  base;
    logic [15:0] exp_w;
    cyc++;
    if (!rst_n) begin
      rises      = 0;
      acc_idx    = 0;
      mosi_sh    = '0;
      prev_sck   = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_stop  = 1'b0;
    end else begin
      if (spi_cs_n) begin
        chk(!spi_clk, "sck_idle_low", 32'(spi_clk), 32'd0);
        rises   = 0;
        acc_idx = 0;
        mosi_sh = '0;
      end else if (spi_clk && !prev_sck) begin
        rises++;
        if (rises <= 32) begin
          chk(spi_io0_oe, "oe_cmd_addr", 32'(spi_io0_oe), 32'd1);
          mosi_sh = {mosi_sh[30:0], spi_mosi};
          if (rises == 32)
            chk(mosi_sh == {8'h6B, exp_addr}, "mosi_cmd_addr", mosi_sh, {8'h6B, exp_addr});
        end else begin
          chk(!spi_io0_oe, "oe_released", 32'(spi_io0_oe), 32'd0);
          if (rises < FIRST_DATA) chk(!spi_mosi, "mosi_dummy", 32'(spi_mosi), 32'd0);
        end
        if (rises >= FIRST_DATA) spi_miso = stream[8'(rises - FIRST_DATA)];
      end
      if (prev_valid && !prev_ready && !prev_stop)
        chk(data_valid && (data == prev_data), "hold_stable", {15'd0, data_valid, data}, {15'd0, 1'b1, prev_data});
      if (data_valid && data_ready) begin
        base  = 8'(4 * acc_idx);
        exp_w = {stream[base], stream[base + 8'd1], stream[base + 8'd2], stream[base + 8'd3]};
        chk(data == exp_w, "word", 32'(data), 32'(exp_w));
        got_words.push_back(data);
        got_cyc.push_back(cyc);
        acc_idx++;
      end
      prev_sck   = spi_clk;
      prev_valid = data_valid;
      prev_ready = data_ready;
      prev_stop  = stop;
      prev_data  = data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_stream(input bit fixed_head);
    for (int i = 0; i < 256; i++) stream[i] = 4'($urandom);
    if (fixed_head) begin
      stream[0] = 4'hA; stream[1] = 4'hB; stream[2] = 4'hC; stream[3] = 4'hD;
      stream[4] = 4'h1; stream[5] = 4'h2; stream[6] = 4'h3; stream[7] = 4'h4;
    end
  endtask

  task automatic do_start(input logic [23:0] a, input bit expect_accept);
    tick();
    start = 1'b1;
    addr  = a;
    if (expect_accept) begin
      exp_addr = a;
      chk(spi_cs_n, "cs_before_start", 32'(spi_cs_n), 32'd1);
    end
    tick();
    start = 1'b0;
    addr  = 24'($urandom);
    if (expect_accept)
      chk(!spi_cs_n && busy && spi_io0_oe, "start_cs_fall",
          {29'd0, spi_cs_n, busy, spi_io0_oe}, 32'b011);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk(spi_cs_n && !spi_clk && !spi_io0_oe && !data_valid && busy, "stop_effect",
        {27'd0, spi_cs_n, spi_clk, spi_io0_oe, data_valid, busy}, 32'b10001);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk(!busy, "idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (got_words.size() < n && c < budget) begin tick(); c++; end
    chk(got_words.size() >= n, "word_timeout", 32'(got_words.size()), 32'(n));
    while (got_words.size() < n) begin got_words.push_back('0); got_cyc.push_back(0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int hi;
    fill_stream(1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk({spi_cs_n, spi_clk, spi_mosi, spi_io0_oe, busy, data_valid} == 6'b100000, "reset_ctrl",
        {26'd0, spi_cs_n, spi_clk, spi_mosi, spi_io0_oe, busy, data_valid}, 32'b100000);
    chk(data == 16'h0, "reset_data", 32'(data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic read: words and spacing
    fill_stream(1'b1);
    ready_force = 1'b1;
    got_words.delete(); got_cyc.delete();
    do_start(24'h123456, 1'b1);
    wait_words(2, 200);
    chk(got_words[0] == 16'hABCD, "first_word", 32'(got_words[0]), 32'hABCD);
    chk(got_words[1] == 16'h1234, "second_word", 32'(got_words[1]), 32'h1234);
    chk(got_cyc[1] - got_cyc[0] == 8, "valid_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'd8);
    tick();
    do_stop();
    wait_idle();

    // Back-pressure: hold first word for 40 cycles
    fill_stream(1'b1);
    ready_force = 1'b0;
    got_words.delete(); got_cyc.delete();
    do_start(24'($urandom), 1'b1);
    c = 0;
    while (!data_valid && c < 200) begin tick(); c++; end
    chk(data_valid, "bp_first_valid", 32'(data_valid), 32'd1);
    repeat (40) tick();
    chk(!spi_clk && !spi_cs_n, "bp_stalled", {30'd0, spi_clk, spi_cs_n}, 32'd0);
    chk(data == 16'hABCD && data_valid, "bp_data_held", {15'd0, data_valid, data}, 32'h1ABCD);
    chk(rises == FIRST_DATA + 7, "bp_sck_count", 32'(rises), 32'(FIRST_DATA + 7));
    chk(got_words.size() == 0, "bp_no_accept", 32'(got_words.size()), 32'd0);
    ready_force = 1'b1;
    wait_words(4, 100);
    chk(got_words[0] == 16'hABCD, "bp_word0", 32'(got_words[0]), 32'hABCD);
    chk(got_words[1] == 16'h1234, "bp_word1", 32'(got_words[1]), 32'h1234);
    do_stop();
    wait_idle();

    // Stop mid-word, start during CSH ignored
    fill_stream(1'b0);
    got_words.delete(); got_cyc.delete();
    do_start(24'($urandom), 1'b1);
    c = 0;
    while (!(rises == FIRST_DATA + 1 && !spi_clk) && c < 200) begin tick(); c++; end
    chk(rises == FIRST_DATA + 1, "midword_reach", 32'(rises), 32'(FIRST_DATA + 1));
    do_stop();
    start = 1'b1;
    addr  = 24'hFFFFFF;
    hi = 0;
    c  = 0;
    while (busy && c < 20) begin
      hi++;
      chk(spi_cs_n, "csh_cs_high", 32'(spi_cs_n), 32'd1);
      tick();
      start = 1'b0;
      c++;
    end
    start = 1'b0;
    chk(hi >= CSH && hi <= CSH + 1, "csh_length", 32'(hi), 32'(CSH));
    for (int i = 0; i < 6; i++) begin
      chk(!busy && spi_cs_n, "csh_start_ignored", {30'd0, busy, spi_cs_n}, 32'b01);
      tick();
    end
    chk(got_words.size() == 0, "partial_discarded", 32'(got_words.size()), 32'd0);

    // Start while streaming must not disturb the read
    fill_stream(1'b0);
    rand_ready = 1'b1;
    got_words.delete(); got_cyc.delete();
    do_start(24'($urandom), 1'b1);
    wait_words(3, 400);
    do_start(~exp_addr, 1'b0);
    chk(!spi_cs_n && busy, "start_in_data", {30'd0, spi_cs_n, busy}, 32'b01);
    wait_words(8, 400);
    do_stop();
    wait_idle();

    // Asynchronous reset during ADDR
    rand_ready = 1'b0;
    ready_force = 1'b1;
    fill_stream(1'b0);
    do_start(24'($urandom), 1'b1);
    c = 0;
    while (rises < 15 && c < 100) begin tick(); c++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk({spi_cs_n, spi_clk, spi_mosi, spi_io0_oe, busy, data_valid} == 6'b100000, "async_reset",
        {26'd0, spi_cs_n, spi_clk, spi_mosi, spi_io0_oe, busy, data_valid}, 32'b100000);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    fill_stream(1'b0);
    got_words.delete(); got_cyc.delete();
    do_start(24'($urandom), 1'b1);
    wait_words(4, 300);
    do_stop();
    wait_idle();

    // Random transactions
    rand_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      fill_stream(1'b0);
      got_words.delete(); got_cyc.delete();
      do_start(24'($urandom), 1'b1);
      repeat ($urandom_range(200, 350)) tick();
      chk(got_words.size() >= 1, "rand_words", 32'(got_words.size()), 32'd1);
      do_stop();
      wait_idle();
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
